// File: rtl/multi_toggle_counter.sv
// multi_toggle_counter: per-channel debounced toggle switch driving an up/down
// counter, all channels paced by one internal prescaler tick.
// Optional build macro MULTI_TOGGLE_COUNTER_SATURATE_EN: counters saturate and
// ovf becomes a sticky level; without it counters wrap and ovf is a 1-cycle pulse.
module multi_toggle_counter #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 8,
    parameter int RATIO       = 10,
    parameter int DEB_SAMPLES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sw,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       clr,
    output logic                      tick,
    output logic [CHANNELS-1:0]       run,
    output logic [CHANNELS*CNT_W-1:0] cnt,
    output logic [CHANNELS-1:0]       ovf
);

    localparam int PS_W = $clog2(RATIO);

    logic [PS_W-1:0]          ps_cnt;
    logic [DEB_SAMPLES-2:0]   hist  [CHANNELS];
    logic [DEB_SAMPLES-1:0]   win   [CHANNELS];
    logic [CHANNELS-1:0]      deb;
    logic [CHANNELS-1:0]      deb_q;
    logic [CHANNELS-1:0]      press;
    logic [CNT_W-1:0]         cnt_r [CHANNELS];

    // Prescaler: free-running 0..RATIO-1, registered one-cycle tick on wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else begin
            tick   <= (ps_cnt == PS_W'(RATIO - 1));
            ps_cnt <= (ps_cnt == PS_W'(RATIO - 1)) ? '0 : ps_cnt + PS_W'(1);
        end
    end

    // Sample window per channel: stored history plus the live switch value
    always_comb begin
        win = '{default: '0};
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            win[i] = {hist[i], sw[i]};
        end
    end

    // Debounce on tick cycles and keep a one-cycle-delayed copy for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            hist  <= '{default: '0};
            deb   <= '0;
            deb_q <= '0;
        end else begin
            deb_q <= deb;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (tick) begin
                    hist[i] <= win[i][DEB_SAMPLES-2:0];
                    if (&win[i]) begin
                        deb[i] <= 1'b1;
                    end else if (~|win[i]) begin
                        deb[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign press = deb & ~deb_q;

    // Run toggle and counter per channel; clr overrides both press and count
    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= '0;
            ovf   <= '0;
            cnt_r <= '{default: '0};
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (clr[i]) begin
                    run[i]   <= 1'b0;
                    ovf[i]   <= 1'b0;
                    cnt_r[i] <= '0;
                end else begin
                    if (press[i]) begin
                        run[i] <= ~run[i];
                    end
`ifdef MULTI_TOGGLE_COUNTER_SATURATE_EN
                    if (tick && run[i]) begin
                        if (dir[i]) begin
                            if (cnt_r[i] == '0) begin
                                ovf[i] <= 1'b1;
                            end else begin
                                cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                                ovf[i]   <= 1'b0;
                            end
                        end else begin
                            if (cnt_r[i] == '1) begin
                                ovf[i] <= 1'b1;
                            end else begin
                                cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                                ovf[i]   <= 1'b0;
                            end
                        end
                    end
`else
                    ovf[i] <= 1'b0;
                    if (tick && run[i]) begin
                        if (dir[i]) begin
                            cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                            ovf[i]   <= (cnt_r[i] == '0);
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                            ovf[i]   <= (cnt_r[i] == '1);
                        end
                    end
`endif
                end
            end
        end
    end

    // Pack per-channel counters onto the flat output bus
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end

endmodule

// File: tb/tb_multi_toggle_counter.sv
// Self-checking bench for multi_toggle_counter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_multi_toggle_counter;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int RT   = 10;
    localparam int DB   = 3;
    localparam int MOD  = 1 << CW;
    localparam int MAXV = MOD - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    sw, dir, clr;
    logic             tick;
    logic [CH-1:0]    run, ovf;
    logic [CH*CW-1:0] cnt;

    int tests = 0;
    int errors = 0;

    multi_toggle_counter #(
        .CHANNELS(CH), .CNT_W(CW), .RATIO(RT), .DEB_SAMPLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .dir(dir), .clr(clr),
        .tick(tick), .run(run), .cnt(cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return cnt[ch*CW +: CW];
    endfunction

    // ---------------- behavioural model ----------------
    int  cyc;
    bit  m_tick, m_valid = 1'b0;
    int  m_cnt [CH];
    bit  m_run [CH], m_ovf [CH], m_deb [CH], m_pend [CH];
    int  m_last [CH], m_streak [CH];
    int  nxt;

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; m_tick = 0; m_valid = 1;
            for (int i = 0; i < CH; i++) begin
                m_cnt[i] = 0; m_run[i] = 0; m_ovf[i] = 0; m_deb[i] = 0;
                m_pend[i] = 0; m_last[i] = 0; m_streak[i] = DB - 1;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (clr[i]) begin
                    m_run[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                end else begin
`ifndef MULTI_TOGGLE_COUNTER_SATURATE_EN
                    m_ovf[i] = 0;
`endif
                    if (m_tick && m_run[i]) begin
                        nxt = m_cnt[i] + (dir[i] ? -1 : 1);
`ifdef MULTI_TOGGLE_COUNTER_SATURATE_EN
                        if (nxt < 0 || nxt > MAXV) m_ovf[i] = 1;
                        else begin m_cnt[i] = nxt; m_ovf[i] = 0; end
`else
                        if (nxt < 0 || nxt > MAXV) m_ovf[i] = 1;
                        m_cnt[i] = (nxt + MOD) % MOD;
`endif
                    end
                    if (m_pend[i]) m_run[i] = !m_run[i];
                end
                m_pend[i] = 0;
                if (m_tick) begin
                    if (int'(sw[i]) == m_last[i]) begin
                        if (m_streak[i] < DB) m_streak[i]++;
                    end else begin
                        m_last[i] = int'(sw[i]); m_streak[i] = 1;
                    end
                    if (m_streak[i] >= DB && int'(m_deb[i]) != m_last[i]) begin
                        m_deb[i]  = (m_last[i] == 1);
                        m_pend[i] = m_deb[i];
                    end
                end
            end
            cyc++;
            m_tick = (cyc % RT == 0);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [CH*CW-1:0] ev;
        logic [CH-1:0]    er, eo;
        if (m_valid) begin
            for (int i = 0; i < CH; i++) begin
                ev[i*CW +: CW] = CW'(m_cnt[i]);
                er[i] = m_run[i];
                eo[i] = m_ovf[i];
            end
            chk("model_tick", 64'(tick), 64'(m_tick));
            chk("model_run",  64'(run),  64'(er));
            chk("model_cnt",  64'(cnt),  64'(ev));
            chk("model_ovf",  64'(ovf),  64'(eo));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 3 * RT);
        chk("tick_wait", 64'(tick), 64'd1);
    endtask

    task automatic press(input int ch);
        for (int k = 0; k < DB; k++) begin next_tick(); sw[ch] = 1'b1; end
        for (int k = 0; k < DB; k++) begin next_tick(); sw[ch] = 1'b0; end
    endtask

    initial begin
        int c1;
        rst = 1'b1; sw = '0; dir = '0; clr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Prescaler: tick on cycles 10, 20, 30 after release, nothing else moves
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            chk("tick_cycle", 64'(tick), 64'(k % RT == 0));
        end
        chk("idle_outputs", 64'({run, cnt, ovf}), 64'd0);

        // Glitch of two samples on channel 0 is rejected
        next_tick(); sw[0] = 1'b1;
        next_tick(); sw[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin next_tick(); sw[0] = 1'b0; end
        next_tick();
        chk("glitch_run", 64'(run[0]), 64'd0);
        chk("glitch_cnt", 64'(cnt_of(0)), 64'd0);

        // Channel 1: press, count up, second press stops at the held value
        for (int t = 1; t <= 14; t++) begin
            next_tick();
            sw[1] = (t <= 5) || (t >= 9 && t <= 11);
            if (t == 3) begin
                @(negedge clk); chk("run_before_toggle", 64'(run[1]), 64'd0);
                @(negedge clk); chk("run_after_toggle",  64'(run[1]), 64'd1);
            end
            if (t == 4)  chk("cnt1_t4", 64'(cnt_of(1)), 64'd0);
            if (t == 5)  chk("cnt1_t5", 64'(cnt_of(1)), 64'd1);
            if (t == 6)  chk("cnt1_t6", 64'(cnt_of(1)), 64'd2);
            if (t == 12) begin
                chk("cnt1_stopped", 64'(cnt_of(1)), 64'd8);
                chk("run1_stopped", 64'(run[1]), 64'd0);
            end
            if (t == 14) chk("cnt1_held", 64'(cnt_of(1)), 64'd8);
        end

        // Channel 2: reach 1 counting up, then count down through zero
        for (int k = 0; k < DB; k++) begin next_tick(); sw[2] = 1'b1; end
        next_tick(); sw[2] = 1'b0;
        chk("cnt2_start", 64'(cnt_of(2)), 64'd0);
        @(negedge clk); dir[2] = 1'b1;
        chk("cnt2_one", 64'(cnt_of(2)), 64'd1);
        next_tick();
        chk("cnt2_pre_dec", 64'(cnt_of(2)), 64'd1);
        @(negedge clk);
        chk("cnt2_zero", 64'(cnt_of(2)), 64'd0);
        chk("ovf2_zero", 64'(ovf[2]), 64'd0);
        next_tick();
        chk("cnt2_pre_wrap", 64'(cnt_of(2)), 64'd0);
        @(negedge clk);
`ifdef MULTI_TOGGLE_COUNTER_SATURATE_EN
        chk("cnt2_sat", 64'(cnt_of(2)), 64'd0);
        chk("ovf2_set", 64'(ovf[2]), 64'd1);
        @(negedge clk);
        chk("ovf2_held", 64'(ovf[2]), 64'd1);
`else
        chk("cnt2_wrap", 64'(cnt_of(2)), 64'd255);
        chk("ovf2_pulse", 64'(ovf[2]), 64'd1);
        @(negedge clk);
        chk("ovf2_pulse_end", 64'(ovf[2]), 64'd0);
`endif

        // Priority: clr on channel 0 beats a press, channel 1 keeps counting
        press(1);
        press(0);
        press(0);
        chk("cnt0_nonzero", 64'(cnt_of(0) != 0), 64'd1);
        for (int k = 1; k <= DB; k++) begin
            next_tick(); sw[0] = 1'b1;
            if (k == DB) begin
                clr[0] = 1'b1;
                c1 = m_cnt[1];
                @(negedge clk);
                chk("clr_cnt0", 64'(cnt_of(0)), 64'd0);
                chk("clr_run0", 64'(run[0]), 64'd0);
                chk("ch1_counts", 64'(cnt_of(1)), 64'((c1 + 1) % MOD));
                @(negedge clk);
                chk("clr_beats_press", 64'(run[0]), 64'd0);
                clr[0] = 1'b0;
                @(negedge clk);
                chk("press_consumed", 64'(run[0]), 64'd0);
            end
        end
        for (int k = 0; k < DB; k++) begin next_tick(); sw[0] = 1'b0; end

`ifdef MULTI_TOGGLE_COUNTER_SATURATE_EN
        // Channel 3 counts up into the upper limit and sticks there
        dir[3] = 1'b0;
        press(3);
        for (int n = 0; n < 300 && m_cnt[3] != 254; n++) next_tick();
        chk("cnt3_at_254", 64'(cnt_of(3)), 64'd254);
        @(negedge clk);
        chk("cnt3_255", 64'(cnt_of(3)), 64'd255);
        chk("ovf3_clear", 64'(ovf[3]), 64'd0);
        next_tick(); @(negedge clk);
        chk("cnt3_stuck", 64'(cnt_of(3)), 64'd255);
        chk("ovf3_set", 64'(ovf[3]), 64'd1);
        next_tick(); @(negedge clk);
        chk("ovf3_held", 64'(ovf[3]), 64'd1);
        clr[3] = 1'b1; @(negedge clk); clr[3] = 1'b0;
        chk("ovf3_cleared", 64'(ovf[3]), 64'd0);
        chk("cnt3_cleared", 64'(cnt_of(3)), 64'd0);
`endif

        // Randomized traffic; the model comparison runs every cycle
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 1999) == 0);
            if (tick) begin
                for (int i = 0; i < CH; i++) begin
                    if ($urandom_range(0, 3) == 0) sw[i] = ~sw[i];
                    if ($urandom_range(0, 7) == 0) dir[i] = ~dir[i];
                end
            end
            for (int i = 0; i < CH; i++) clr[i] = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0; clr = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
